led_pattern_sequencer: RTL

//   Controller that sequences the four board LEDs through selectable display patterns.
//   An internal prescaler derives a step tick from CLK_12_MHZ, and a valid/ready

---
 rtl/led_seq_pkg.sv | 49 ++++
 rtl/led_tick_gen.sv | 39 +++
 rtl/led_pattern_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_pkg
// Description : Shared encodings for the LED pattern sequencer: mode codes,
//               FSM state codes, frame-0 constants per mode and the pattern
//               helper functions used by the top.
// Revision    : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

    // Requested / active display mode
    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_COUNT = 2'd1;
    localparam logic [1:0] MODE_CHASE = 2'd2;
    localparam logic [1:0] MODE_BLINK = 2'd3;

    // Sequencer FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SWITCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    // First frame shown by each mode
    localparam logic [3:0] FRAME0_OFF   = 4'b0000;
    localparam logic [3:0] FRAME0_COUNT = 4'b0000;
    localparam logic [3:0] FRAME0_CHASE = 4'b0001;
    localparam logic [3:0] FRAME0_BLINK = 4'b1111;

    // Highest step index before the pattern wraps back to frame 0
    function automatic logic [3:0] last_step(input logic [1:0] mode);
        case (mode)
            MODE_COUNT: last_step = 4'd15;
            MODE_CHASE: last_step = 4'd3;
            MODE_BLINK: last_step = 4'd1;
            default:    last_step = 4'd0;
        endcase
    endfunction

    // LED image for a given mode and step index
    function automatic logic [3:0] frame_of(input logic [1:0] mode, input logic [3:0] step);
        case (mode)
            MODE_COUNT: frame_of = FRAME0_COUNT + step;
            MODE_CHASE: frame_of = FRAME0_CHASE << step[1:0];
            MODE_BLINK: frame_of = step[0] ? 4'b0000 : FRAME0_BLINK;
            default:    frame_of = FRAME0_OFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_tick_gen
// Description : Pattern-step prescaler. Counts 0..TICK_DIV-1 while enabled and
//               flags the terminal count as a step tick.
//   CLK_12_MHZ  in  1  clock
//   reset       in  1  synchronous active-high reset
//   enable      in  1  count this cycle
//   clear       in  1  force the count back to 0 (has priority over enable)
//   tick        out 1  high while enabled at the terminal count
// Revision    : 1.0 - initial release
// ============================================================================
module led_tick_gen #(
    parameter int TICK_DIV = 6000000,
    parameter int CNT_W    = 23
) (
    input  logic CLK_12_MHZ,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK_12_MHZ) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign tick = enable && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_sequencer
// Description : Steps the four board LEDs through OFF/COUNT/CHASE/BLINK
//               patterns at a prescaled rate; modes change via a valid/ready
//               request port. Optional PWM dimming when LED_PWM_EN is defined.
//   CLK_12_MHZ      in  1  clock
//   reset           in  1  synchronous active-high reset
//   mode_req_valid  in  1  new mode presented
//   mode_req        in  2  requested mode
//   mode_req_ready  out 1  request accepted when valid && ready
//   brightness      in  4  PWM duty 0..15 (LED_PWM_EN builds only)
//   led             out 4  LED drive
//   frame_done      out 1  pulse when the pattern wraps to frame 0
//   busy            out 1  high in SWITCH and RUN
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 6000000,
    parameter int CNT_W    = 23
) (
    input  logic       CLK_12_MHZ,
    input  logic       reset,
    input  logic       mode_req_valid,
    input  logic [1:0] mode_req,
    output logic       mode_req_ready,
`ifdef LED_PWM_EN
    input  logic [3:0] brightness,
`endif
    output logic [3:0] led,
    output logic       frame_done,
    output logic       busy
);

    logic [1:0] r_state;
    logic [1:0] r_mode;
    logic [3:0] r_step;
    logic [3:0] r_pattern;
    logic       r_frame_done;
    logic       r_busy;

    logic       w_xfer;
    logic       w_tick;
    logic [3:0] w_step_next;

    assign mode_req_ready = (r_state != ST_SWITCH);
    assign w_xfer         = mode_req_valid && mode_req_ready;
    assign w_step_next    = (r_step == last_step(r_mode)) ? 4'd0 : r_step + 4'd1;

    // Prescaler restarts from 0 in SWITCH so the first frame gets a full step
    led_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .CLK_12_MHZ (CLK_12_MHZ),
        .reset      (reset),
        .enable     (r_state == ST_RUN),
        .clear      (r_state == ST_SWITCH),
        .tick       (w_tick)
    );

    always_ff @(posedge CLK_12_MHZ) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_mode       <= MODE_OFF;
            r_step       <= 4'd0;
            r_pattern    <= 4'd0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer && mode_req != MODE_OFF) begin
                        r_state   <= ST_SWITCH;
                        r_mode    <= mode_req;
                        r_busy    <= 1'b1;
                        r_pattern <= 4'd0;
                    end
                end
                ST_SWITCH: begin
                    r_state   <= ST_RUN;
                    r_step    <= 4'd0;
                    r_pattern <= frame_of(r_mode, 4'd0);
                end
                ST_RUN: begin
                    // An accepted request takes precedence over a coincident tick
                    if (w_xfer) begin
                        r_pattern <= 4'd0;
                        if (mode_req == MODE_OFF) begin
                            r_state <= ST_IDLE;
                            r_mode  <= MODE_OFF;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_SWITCH;
                            r_mode  <= mode_req;
                        end
                    end else if (w_tick) begin
                        r_step       <= w_step_next;
                        r_pattern    <= frame_of(r_mode, w_step_next);
                        r_frame_done <= (w_step_next == 4'd0);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mode    <= MODE_OFF;
                    r_pattern <= 4'd0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef LED_PWM_EN
    // Free-running duty counter; LEDs are lit while it is below brightness
    logic [3:0] r_pwm_cnt;

    always_ff @(posedge CLK_12_MHZ) begin
        if (reset) begin
            r_pwm_cnt <= 4'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    assign led = r_pattern & {4{r_pwm_cnt < brightness}};
`else
    assign led = r_pattern;
`endif

    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule
`default_nettype wire
